stats_window_seq: RTL and testbench

- Sequencing controller for the sliding-window average / standard-deviation datapath.
- Requests and captures 12-bit samples, keeps incremental SUM and SUMSQ over the last DEPTH samples, and time-shares one internal iterative divider for mean and mean-square.
- Drives the existing Newton sqrt engine through a start/done handshake and publishes AVG_SD with a DONE pulse.
- Replaces per-sample combinational 14-input adders/dividers with one sequenced datapath.

---
 rtl/stats_window_seq_pkg.sv | 31 +++
 rtl/stats_window_seq_if.sv | 40 ++++
 rtl/stats_window_seq_div.sv | 77 +++++++
 rtl/stats_window_seq.sv | 217 +++++++++++++++++++++
 tb/tb_stats_window_seq.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stats_window_seq_pkg.sv
// -----------------------------------------------------------------------------
// stats_pkg
// Shared definitions for the sliding-window average / standard-deviation
// sequencer: default widths, the derived divider operand width, and the
// state encoding of the controller.
// -----------------------------------------------------------------------------
package stats_pkg;

  localparam int DATA_W_DEF      = 12;   // sample width
  localparam int DEPTH_DEF       = 14;   // window length (2..15)
  localparam int OUT_W_DEF       = 24;   // result width
  localparam int TIMEOUT_CYC_DEF = 255;  // sqrt watchdog limit

  // Divider operand width: wide enough for SUMSQ of a full window.
  function automatic int sq_w(input int data_w);
    return 2 * data_w + 4;
  endfunction

  // Controller states, kept as plain vectors for legacy tooling.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_REQ       = 3'd1;
  localparam state_t ST_UPDATE    = 3'd2;
  localparam state_t ST_DIV_AVG   = 3'd3;
  localparam state_t ST_DIV_SQ    = 3'd4;
  localparam state_t ST_VAR       = 3'd5;
  localparam state_t ST_SQRT_WAIT = 3'd6;
  localparam state_t ST_OUT       = 3'd7;

endpackage

// File: rtl/stats_window_seq_if.sv
// -----------------------------------------------------------------------------
// stats_window_seq_if
// Bundles the run control, sample handshake, result and sqrt-engine
// handshake of stats_window_seq.
//   master : the sequencer side (drives sample, done, avg_sd, sqrt_start,
//            sqrt_in, err)
//   slave  : the environment side (drives en, mode, tn, tn_valid,
//            sqrt_done, sqrt_out)
// -----------------------------------------------------------------------------
interface stats_window_seq_if
  import stats_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
);

  logic              en;
  logic              mode;
  logic [DATA_W-1:0] tn;
  logic              tn_valid;
  logic              sample;
  logic              done;
  logic [OUT_W-1:0]  avg_sd;
  logic              sqrt_start;
  logic [OUT_W-1:0]  sqrt_in;
  logic              sqrt_done;
  logic [OUT_W-1:0]  sqrt_out;
  logic              err;

  modport master (
    input  en, mode, tn, tn_valid, sqrt_done, sqrt_out,
    output sample, done, avg_sd, sqrt_start, sqrt_in, err
  );

  modport slave (
    output en, mode, tn, tn_valid, sqrt_done, sqrt_out,
    input  sample, done, avg_sd, sqrt_start, sqrt_in, err
  );

endinterface

// File: rtl/stats_window_seq_div.sv
// -----------------------------------------------------------------------------
// stats_seq_div
// Restoring unsigned divider, one quotient bit per cycle.
//   clk, RESET : clock, synchronous active-low reset
//   start      : load num/den (ignored while busy)
//   num, den   : dividend / divisor (den must be non-zero)
//   busy       : division in progress
//   done       : one-cycle strobe, NUM_W+1 cycles after start is sampled
//   quo        : quotient, held until the next start
// -----------------------------------------------------------------------------
module stats_seq_div
  import stats_pkg::*;
#(
  parameter int NUM_W = sq_w(DATA_W_DEF),
  parameter int DEN_W = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quo_q;
  logic [DEN_W:0]   rem_q;
  logic [DEN_W-1:0] den_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [DEN_W:0]   trial;
  logic             fits;

  // The remainder is always below den, so DEN_W bits hold it before the shift.
  assign trial = {rem_q[DEN_W-1:0], quo_q[NUM_W-1]};
  assign fits  = (trial >= {1'b0, den_q});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        quo_q  <= num;
        rem_q  <= '0;
        den_q  <= den;
        cnt_q  <= CNT_W'(NUM_W);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          quo_q <= {quo_q[NUM_W-2:0], fits};
          rem_q <= fits ? (trial - {1'b0, den_q}) : trial;
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = quo_q;

endmodule

// File: rtl/stats_window_seq.sv
// -----------------------------------------------------------------------------
// stats_window_seq
// Sequencing controller for the sliding-window average / std-deviation path.
// Requests samples, keeps running SUM / SUMSQ over the last DEPTH samples,
// shares one iterative divider for mean and mean-square, and hands the
// variance to an external sqrt engine.
//   clk   : clock, rising edge
//   RESET : synchronous active-low reset
//   bus   : stats_window_seq_if.master (en, mode, tn/tn_valid, sample, done,
//           avg_sd, sqrt_start/sqrt_in, sqrt_done/sqrt_out, err)
// Optional build macro STATS_SQRT_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on
// the sqrt wait with a sticky err flag; without it err is constant 0.
// -----------------------------------------------------------------------------
module stats_window_seq
  import stats_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            clk,
  input  logic            RESET,
  stats_window_seq_if.master bus
);

  localparam int SQ_W  = sq_w(DATA_W);
  localparam int SUM_W = DATA_W + 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int P_W   = 2 * DATA_W;

  state_t            state_q;
  logic [DATA_W-1:0] win_q [DEPTH];
  logic [SUM_W-1:0]  sum_q;
  logic [SQ_W-1:0]   sumsq_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] tn_q;
  logic              mode_q;
  logic [DATA_W-1:0] avg_q;
  logic [SQ_W-1:0]   msq_q;
  logic              done_q;
  logic [OUT_W-1:0]  avg_sd_q;
  logic              sqrt_start_q;
  logic [OUT_W-1:0]  sqrt_in_q;

  // Running-sum update: the oldest sample only leaves once the window is full.
  logic              full;
  logic [DATA_W-1:0] old_s;
  logic [P_W-1:0]    tn_sq, old_sq, avg_sq;
  logic [SUM_W-1:0]  sum_next;
  logic [SQ_W-1:0]   sumsq_next;
  logic [CNT_W-1:0]  count_next;
  logic [SQ_W-1:0]   var_val;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign old_s      = full ? win_q[DEPTH-1] : '0;
  assign tn_sq      = P_W'(tn_q) * P_W'(tn_q);
  assign old_sq     = P_W'(old_s) * P_W'(old_s);
  assign avg_sq     = P_W'(avg_q) * P_W'(avg_q);
  assign sum_next   = sum_q + SUM_W'(tn_q) - SUM_W'(old_s);
  assign sumsq_next = sumsq_q + SQ_W'(tn_sq) - SQ_W'(old_sq);
  assign count_next = full ? count_q : count_q + CNT_W'(1);
  // Flooring both quotients can in principle push msq below avg^2; clamp.
  assign var_val    = (msq_q >= SQ_W'(avg_sq)) ? (msq_q - SQ_W'(avg_sq)) : '0;

  // Shared divider: mean is launched from UPDATE with the post-update sums,
  // mean-square is launched the cycle the mean result is consumed.
  logic             div_start, div_busy, div_done;
  logic [SQ_W-1:0]  div_num, div_quo;
  logic [CNT_W-1:0] div_den;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch is inferred.
  always_comb begin
    div_start = 1'b0;
    div_num   = SQ_W'(sum_next);
    div_den   = count_next;
    case (state_q)
      ST_UPDATE:  div_start = !div_busy;
      ST_DIV_AVG: begin
        div_start = div_done && mode_q;
        div_num   = sumsq_q;
        div_den   = count_q;
      end
      default: ;
    endcase
  end

  stats_seq_div #(
    .NUM_W (SQ_W),
    .DEN_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .RESET (RESET),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

`ifdef STATS_SQRT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
`endif

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      // NOTE: the window is a small flop array, not RAM, so it is cleared on
      // reset together with the running sums it feeds.
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      sum_q        <= '0;
      sumsq_q      <= '0;
      count_q      <= '0;
      tn_q         <= '0;
      mode_q       <= 1'b0;
      avg_q        <= '0;
      msq_q        <= '0;
      done_q       <= 1'b0;
      avg_sd_q     <= '0;
      sqrt_start_q <= 1'b0;
      sqrt_in_q    <= '0;
`ifdef STATS_SQRT_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      done_q       <= 1'b0;
      sqrt_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.en) state_q <= ST_REQ;
        ST_REQ: begin
          if (bus.tn_valid) begin
            tn_q    <= bus.tn;
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          win_q[0] <= tn_q;
          for (int i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
          sum_q    <= sum_next;
          sumsq_q  <= sumsq_next;
          count_q  <= count_next;
          mode_q   <= bus.mode;
          state_q  <= ST_DIV_AVG;
        end
        ST_DIV_AVG: begin
          if (div_done) begin
            avg_q <= div_quo[DATA_W-1:0];
            if (mode_q) begin
              state_q <= ST_DIV_SQ;
            end else begin
              avg_sd_q <= OUT_W'(div_quo[DATA_W-1:0]);
              done_q   <= 1'b1;
              state_q  <= ST_OUT;
            end
          end
        end
        ST_DIV_SQ: begin
          if (div_done) begin
            msq_q   <= div_quo;
            state_q <= ST_VAR;
          end
        end
        ST_VAR: begin
          if (var_val == '0) begin
            avg_sd_q <= '0;
            done_q   <= 1'b1;
            state_q  <= ST_OUT;
          end else begin
            sqrt_in_q    <= OUT_W'(var_val);
            sqrt_start_q <= 1'b1;
            state_q      <= ST_SQRT_WAIT;
`ifdef STATS_SQRT_TIMEOUT_EN
            wd_q         <= '0;
`endif
          end
        end
        ST_SQRT_WAIT: begin
          if (bus.sqrt_done) begin
            avg_sd_q <= bus.sqrt_out;
            done_q   <= 1'b1;
            state_q  <= ST_OUT;
          end
`ifdef STATS_SQRT_TIMEOUT_EN
          else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            avg_sd_q <= '1;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= ST_OUT;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        ST_OUT:  state_q <= bus.en ? ST_REQ : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.sample     = (state_q == ST_REQ);
  assign bus.done       = done_q;
  assign bus.avg_sd     = avg_sd_q;
  assign bus.sqrt_start = sqrt_start_q;
  assign bus.sqrt_in    = sqrt_in_q;
`ifdef STATS_SQRT_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  // No watchdog in this build: err is constant 0 and the limit has no effect.
  assign bus.err        = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_stats_window_seq.sv
module tb_stats_window_seq;
  import stats_pkg::*;

  localparam int DATA_W = 12;
  localparam int OUT_W  = 24;
  localparam int SQ_W   = 2 * DATA_W + 4;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  stats_window_seq_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  stats_window_seq #(
    .DATA_W      (DATA_W),
    .DEPTH       (14),
    .OUT_W       (OUT_W),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent wait_done call.
  bit              got_done;
  int              lat;
  int              n_starts;
  logic [OUT_W-1:0] cap_sqrt_in;
  bit              sqrt_in_stable;

  function automatic logic [OUT_W-1:0] isqrt(input logic [OUT_W-1:0] x);
    logic [OUT_W-1:0] r = '0;
    while (((r + 1) * (r + 1)) <= x) r++;
    return r;
  endfunction

  task automatic apply_reset();
    RESET          = 1'b0;
    bus.en         = 1'b0;
    bus.mode       = 1'b0;
    bus.tn         = '0;
    bus.tn_valid   = 1'b0;
    bus.sqrt_done  = 1'b0;
    bus.sqrt_out   = '0;
    repeat (3) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
  endtask

  // Waits for SAMPLE, presents one sample for one clock, returns on the
  // first falling edge after capture.
  task automatic send_sample(input logic [DATA_W-1:0] val);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.sample === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sample_request: SAMPLE never rose within 64 cycles (value %0d)", val);
    end
    bus.tn       = val;
    bus.tn_valid = 1'b1;
    @(negedge clk);
    bus.tn_valid = 1'b0;
  endtask

  // Counts cycles from capture to DONE; optionally acts as sqrt engine
  // answering resp_delay cycles after SQRT_START.
  task automatic wait_done(input int max_cyc, input int resp_delay, input bit respond);
    int countdown = 0;
    got_done       = 1'b0;
    n_starts       = 0;
    sqrt_in_stable = 1'b1;
    cap_sqrt_in    = '0;
    for (lat = 0; lat < max_cyc; lat++) begin
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      bus.sqrt_done = 1'b0;
      if (respond && countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.sqrt_out  = isqrt(cap_sqrt_in);
          bus.sqrt_done = 1'b1;
        end
      end
      if (bus.sqrt_start === 1'b1) begin
        n_starts++;
        cap_sqrt_in = bus.sqrt_in;
        countdown   = resp_delay;
      end else if (n_starts > 0 && bus.sqrt_in !== cap_sqrt_in) begin
        sqrt_in_stable = 1'b0;
      end
      @(negedge clk);
    end
    bus.sqrt_done = 1'b0;
    n_checks++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL done_timeout: DONE not seen within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.sample !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %b want 0", bus.sample); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.avg_sd !== 24'd0) begin n_fail++; $display("FAIL reset_avg_sd: got %0h want 0", bus.avg_sd); end
    n_checks++; if (bus.sqrt_start !== 1'b0) begin n_fail++; $display("FAIL reset_sqrt_start: got %b want 0", bus.sqrt_start); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
  endtask

  task automatic test_single_avg();
    apply_reset();
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    send_sample(12'd100);
    n_checks++; if (bus.sample !== 1'b0) begin n_fail++; $display("FAIL single_sample_drop: got %b want 0", bus.sample); end
    wait_done(200, 5, 1'b1);
    n_checks++; if (lat != SQ_W + 3) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, SQ_W + 3); end
    n_checks++; if (bus.avg_sd !== 24'd100) begin n_fail++; $display("FAIL single_avg: got %0d want 100", bus.avg_sd); end
    n_checks++; if (n_starts != 0) begin n_fail++; $display("FAIL single_no_sqrt: got %0d starts want 0", n_starts); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", bus.done); end
    n_checks++; if (bus.avg_sd !== 24'd100) begin n_fail++; $display("FAIL single_avg_hold: got %0d want 100", bus.avg_sd); end
  endtask

  task automatic test_window_wrap();
    apply_reset();
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    for (int v = 1; v <= 15; v++) begin
      send_sample(DATA_W'(v));
      wait_done(200, 5, 1'b1);
      if (v == 14) begin
        n_checks++; if (bus.avg_sd !== 24'd7) begin n_fail++; $display("FAIL wrap_avg14: got %0d want 7", bus.avg_sd); end
      end
    end
    n_checks++; if (bus.avg_sd !== 24'd8) begin n_fail++; $display("FAIL wrap_avg15: got %0d want 8", bus.avg_sd); end
    n_checks++; if (dut.sum_q !== 16'd119) begin n_fail++; $display("FAIL wrap_sum: got %0d want 119", dut.sum_q); end
    n_checks++; if (dut.count_q !== 4'd14) begin n_fail++; $display("FAIL wrap_count: got %0d want 14", dut.count_q); end
    n_checks++; if (dut.win_q[0] !== 12'd15) begin n_fail++; $display("FAIL wrap_newest: got %0d want 15", dut.win_q[0]); end
    n_checks++; if (dut.win_q[13] !== 12'd2) begin n_fail++; $display("FAIL wrap_oldest: got %0d want 2", dut.win_q[13]); end
  endtask

  task automatic test_std();
    apply_reset();
    bus.en   = 1'b1;
    bus.mode = 1'b1;
    send_sample(12'd0);
    wait_done(300, 5, 1'b1);
    n_checks++; if (bus.avg_sd !== 24'd0) begin n_fail++; $display("FAIL std_first: got %0d want 0", bus.avg_sd); end
    send_sample(12'd4);
    wait_done(300, 5, 1'b1);
    n_checks++; if (n_starts != 1) begin n_fail++; $display("FAIL std_start_count: got %0d want 1", n_starts); end
    n_checks++; if (cap_sqrt_in !== 24'd4) begin n_fail++; $display("FAIL std_sqrt_in: got %0d want 4", cap_sqrt_in); end
    n_checks++; if (!sqrt_in_stable) begin n_fail++; $display("FAIL std_sqrt_in_stable: got changing want stable"); end
    n_checks++; if (bus.avg_sd !== 24'd2) begin n_fail++; $display("FAIL std_result: got %0d want 2", bus.avg_sd); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL std_err: got %b want 0", bus.err); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL std_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_var_zero();
    int total_starts = 0;
    apply_reset();
    bus.en   = 1'b1;
    bus.mode = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send_sample(12'd50);
      wait_done(300, 5, 1'b1);
      total_starts += n_starts;
    end
    n_checks++; if (total_starts != 0) begin n_fail++; $display("FAIL varzero_starts: got %0d want 0", total_starts); end
    n_checks++; if (bus.avg_sd !== 24'd0) begin n_fail++; $display("FAIL varzero_result: got %0d want 0", bus.avg_sd); end
    n_checks++; if (dut.count_q !== 4'd14) begin n_fail++; $display("FAIL varzero_count: got %0d want 14", dut.count_q); end
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    apply_reset();
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    send_sample(12'd9);
    wait_done(200, 5, 1'b1);
    n_checks++; if (bus.avg_sd !== 24'd9) begin n_fail++; $display("FAIL mid_pre_avg: got %0d want 9", bus.avg_sd); end
    bus.mode = 1'b1;
    send_sample(12'd4);
    for (int i = 0; i < 200; i++) begin
      if (dut.state_q === ST_DIV_SQ) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL mid_reach_div_sq: got not reached want reached"); end
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.sample !== 1'b0) begin n_fail++; $display("FAIL mid_sample: got %b want 0", bus.sample); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", bus.done); end
    n_checks++; if (bus.avg_sd !== 24'd0) begin n_fail++; $display("FAIL mid_avg_sd: got %0d want 0", bus.avg_sd); end
    n_checks++; if (dut.count_q !== 4'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", dut.count_q); end
    bus.en = 1'b0;
    RESET  = 1'b1;
    @(negedge clk);
    bus.sqrt_out  = 24'd55;
    bus.sqrt_done = 1'b1;
    @(negedge clk);
    bus.sqrt_done = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL late_sqrt_done: got %b want 0", bus.done); end
    n_checks++; if (bus.avg_sd !== 24'd0) begin n_fail++; $display("FAIL late_sqrt_avg_sd: got %0d want 0", bus.avg_sd); end
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL late_sqrt_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    send_sample(12'd7);
    wait_done(200, 5, 1'b1);
    n_checks++; if (bus.avg_sd !== 24'd7) begin n_fail++; $display("FAIL mid_after_release: got %0d want 7", bus.avg_sd); end
  endtask

`ifdef STATS_SQRT_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    bus.en   = 1'b1;
    bus.mode = 1'b1;
    send_sample(12'd0);
    wait_done(300, 5, 1'b1);
    send_sample(12'd4);
    wait_done(1000, 0, 1'b0);
    n_checks++; if (bus.avg_sd !== 24'hFFFFFF) begin n_fail++; $display("FAIL timeout_result: got %0h want ffffff", bus.avg_sd); end
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", bus.err); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL timeout_done_width: got %b want 0", bus.done); end
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b want 1", bus.err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_avg();
    test_window_wrap();
    test_std();
    test_var_zero();
    test_reset_mid();
`ifdef STATS_SQRT_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish within 1000000 time units");
    $fatal(1, "global timeout");
  end

endmodule
